// File: rtl/game_flow_controller_if.sv
// Spawn handshake between the game sequencer and the obstacle datapath.
//   spawn_req  : sequencer asks for a new obstacle; held until acknowledged
//   spawn_type : obstacle kind 0..2; stable while spawn_req=1
//   spawn_ack  : datapath accepted the pending spawn
interface game_flow_controller_if;
  logic       spawn_req;
  logic [1:0] spawn_type;
  logic       spawn_ack;

  modport master (output spawn_req, output spawn_type, input spawn_ack);
  modport slave  (input spawn_req, input spawn_type, output spawn_ack);
endinterface

// File: rtl/game_flow_controller.sv
// Central T-Rex game sequencer: INIT/RUN/DEAD FSM, scroll-speed ramp and
// pseudo-random obstacle spawn scheduler.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   jump       : debounced jump button level
//   collide    : dino/obstacle pixel overlap
//   spawn      : spawn handshake (master side)
//   game_state : 00 INIT, 01 RUN, 10 DEAD
//   dx         : scroll pixels per frame, 0 outside RUN
package game_flow_controller_pkg;
  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_t;
endpackage

module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int unsigned DX_INIT     = 5,
  parameter int unsigned DX_MAX      = 12,
  parameter int unsigned RAMP_FRAMES = 600,
  parameter int unsigned GAP_MIN     = 40,
  parameter int unsigned GAP_MASK    = 63,
  parameter int unsigned DEAD_HOLD   = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic                          jump,
  input  logic                          collide,
  game_flow_controller_if.master        spawn,
  output logic [1:0]                    game_state,
  output logic [3:0]                    dx
);

  state_t      state, state_n;
  logic [3:0]  speed, speed_n;
  logic [15:0] ramp_cnt, ramp_n;
  logic [7:0]  gap_cnt, gap_n;
  logic [15:0] hold_cnt, hold_n;
  logic [15:0] lfsr, lfsr_n;
  logic        jump_q;
  logic        req, req_n;
  logic [1:0]  stype, stype_n;
  logic        jump_rise;
  logic [7:0]  gap_load;

  assign jump_rise = jump & ~jump_q;
  assign gap_load  = 8'(16'(GAP_MIN) + (lfsr & 16'(GAP_MASK)));

  assign spawn.spawn_req  = req;
  assign spawn.spawn_type = stype;

  always_comb begin
    state_n = state;
    speed_n = speed;
    ramp_n  = ramp_cnt;
    gap_n   = gap_cnt;
    hold_n  = hold_cnt;
    req_n   = req;
    stype_n = stype;
    lfsr_n  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : '0);

    case (state)
      S_INIT: begin
        speed_n = 4'(DX_INIT);
        ramp_n  = '0;
        gap_n   = '0;
        hold_n  = '0;
        req_n   = 1'b0;
        if (jump_rise) begin
          state_n = S_RUN;
          gap_n   = gap_load;
        end
      end
      S_RUN: begin
        // A collision overrides every other same-cycle update: speed and
        // ramp stay frozen and any pending spawn is dropped.
        if (collide) begin
          state_n = S_DEAD;
          req_n   = 1'b0;
          gap_n   = '0;
        end else begin
          if (frame_tick) begin
            if (ramp_cnt == 16'(RAMP_FRAMES - 1)) begin
              ramp_n = '0;
              if (speed < 4'(DX_MAX)) speed_n = speed + 4'd1;
            end else begin
              ramp_n = ramp_cnt + 16'd1;
            end
          end
          if (req) begin
            if (spawn.spawn_ack) begin
              req_n = 1'b0;
              gap_n = gap_load;
            end
          end else if (gap_cnt == '0) begin
            req_n   = 1'b1;
            stype_n = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
          end else if (frame_tick) begin
            gap_n = gap_cnt - 8'd1;
          end
        end
      end
      S_DEAD: begin
        if (frame_tick && (hold_cnt < 16'(DEAD_HOLD))) hold_n = hold_cnt + 16'd1;
        if (jump_rise && (hold_cnt == 16'(DEAD_HOLD))) state_n = S_INIT;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      speed      <= 4'(DX_INIT);
      ramp_cnt   <= '0;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
      lfsr       <= LFSR_SEED;
      jump_q     <= 1'b1;
      req        <= 1'b0;
      stype      <= '0;
      game_state <= '0;
      dx         <= '0;
    end else begin
      state      <= state_n;
      speed      <= speed_n;
      ramp_cnt   <= ramp_n;
      gap_cnt    <= gap_n;
      hold_cnt   <= hold_n;
      lfsr       <= lfsr_n;
      jump_q     <= jump;
      req        <= req_n;
      stype      <= stype_n;
      // Outputs are registered from next-state values so they line up with
      // the state register without an extra cycle of latency.
      game_state <= state_n;
      dx         <= (state_n == S_RUN) ? speed_n : '0;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       jump;
  logic       collide;
  logic [1:0] game_state;
  logic [3:0] dx;

  game_flow_controller_if sif();

  game_flow_controller #(
    .DX_INIT    (5),
    .DX_MAX     (7),
    .RAMP_FRAMES(4),
    .GAP_MIN    (3),
    .GAP_MASK   (0),
    .DEAD_HOLD  (30),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .jump      (jump),
    .collide   (collide),
    .spawn     (sif),
    .game_state(game_state),
    .dx        (dx)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value the DUT saw at the latest edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic jump_edge();
    jump = 1'b0;
    step();
    jump = 1'b1;
    step();
  endtask

  function automatic logic [1:0] map_type(input logic [15:0] l);
    return (l[1:0] == 2'd3) ? 2'd0 : l[1:0];
  endfunction

  logic [1:0] t_exp;

  initial begin
    rst = 1'b0; jump = 1'b1; collide = 1'b0; frame_tick = 1'b0; sif.spawn_ack = 1'b0;
    #12;
    expect_val("rst_state", 16'd0); check(16'(game_state));
    expect_val("rst_dx", 16'd0);    check(16'(dx));
    expect_val("rst_req", 16'd0);   check(16'(sif.spawn_req));
    expect_val("rst_type", 16'd0);  check(16'(sif.spawn_type));
    step();
    rst = 1'b1;
    repeat (10) step();
    expect_val("held_jump_no_start", 16'd0); check(16'(game_state));

    jump_edge();
    expect_val("start_state", 16'd1); check(16'(game_state));
    expect_val("start_dx", 16'd5);    check(16'(dx));

    // ramp and first spawn
    tick(); tick();
    expect_val("req_before_gap", 16'd0); check(16'(sif.spawn_req));
    tick();
    t_exp = map_type(m_prev);
    expect_val("req_after_gap", 16'd1);  check(16'(sif.spawn_req));
    expect_val("type_first", 16'(t_exp)); check(16'(sif.spawn_type));
    expect_val("dx_t3", 16'd5); check(16'(dx));
    for (int i = 4; i <= 23; i++) begin
      tick();
      if (i == 4)  begin expect_val("dx_t4", 16'd6);  check(16'(dx)); end
      if (i == 7)  begin expect_val("dx_t7", 16'd6);  check(16'(dx)); end
      if (i == 8)  begin expect_val("dx_t8", 16'd7);  check(16'(dx)); end
      if (i == 16) begin expect_val("dx_t16", 16'd7); check(16'(dx)); end
      if (i == 13 || i == 23) begin
        expect_val("req_held", 16'd1);         check(16'(sif.spawn_req));
        expect_val("type_held", 16'(t_exp));   check(16'(sif.spawn_type));
      end
    end

    sif.spawn_ack = 1'b1;
    step();
    sif.spawn_ack = 1'b0;
    expect_val("req_after_ack", 16'd0); check(16'(sif.spawn_req));
    tick(); tick();
    expect_val("req_regap_early", 16'd0); check(16'(sif.spawn_req));
    tick();
    t_exp = map_type(m_prev);
    expect_val("req_regap", 16'd1);        check(16'(sif.spawn_req));
    expect_val("type_second", 16'(t_exp)); check(16'(sif.spawn_type));

    collide = 1'b1;
    step();
    collide = 1'b0;
    expect_val("dead_state", 16'd2); check(16'(game_state));

    // DEAD hold window
    repeat (10) tick();
    jump_edge();
    expect_val("early_restart_ignored", 16'd2); check(16'(game_state));
    repeat (20) tick();
    jump_edge();
    expect_val("restart_to_init", 16'd0); check(16'(game_state));
    jump_edge();
    expect_val("rerun_state", 16'd1); check(16'(game_state));
    expect_val("rerun_dx", 16'd5);    check(16'(dx));

    // collide beats ramp expiry, spawn_ack and frame_tick
    tick(); tick(); tick();
    expect_val("req_second_run", 16'd1); check(16'(sif.spawn_req));
    collide = 1'b1; frame_tick = 1'b1; sif.spawn_ack = 1'b1;
    step();
    collide = 1'b0; frame_tick = 1'b0; sif.spawn_ack = 1'b0;
    expect_val("prio_state", 16'd2); check(16'(game_state));
    expect_val("prio_dx", 16'd0);    check(16'(dx));
    expect_val("prio_req", 16'd0);   check(16'(sif.spawn_req));
    expect_val("prio_speed", 16'd5); check(16'(dut.speed));

    // illegal state code
    force dut.state = state_t'(2'b11);
    step();
    expect_val("illegal_to_init", 16'd0); check(16'(game_state));
    release dut.state;

    // reset in the middle of a pending handshake
    rst = 1'b0;
    step();
    rst = 1'b1;
    jump_edge();
    expect_val("run_after_reset", 16'd1); check(16'(game_state));
    tick(); tick(); tick();
    expect_val("req_before_mid_rst", 16'd1); check(16'(sif.spawn_req));
    #2 rst = 1'b0;
    #1;
    expect_val("mid_rst_state", 16'd0); check(16'(game_state));
    expect_val("mid_rst_dx", 16'd0);    check(16'(dx));
    expect_val("mid_rst_req", 16'd0);   check(16'(sif.spawn_req));
    expect_val("mid_rst_type", 16'd0);  check(16'(sif.spawn_type));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
